// File: rtl/pq_ingress.sv
// Ingress/command stage in front of the register-array priority queue: buffers
// inserts in a small FIFO and sequences enq / deq / replace commands to the PQ.
package pq_pkg;
   parameter int unsigned KEY_WIDTH = 8;
   parameter int unsigned VAL_WIDTH = 8;
endpackage

module pq_ingress
   import pq_pkg::*;
#(
   parameter int unsigned  DEPTH     = 4,
   parameter bit           MIN_FIRST = 1'b1,
   localparam int unsigned KV_W      = KEY_WIDTH + VAL_WIDTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [KV_W-1:0] in_kv,
   input  logic            pop_req,
   output logic            pop_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [KV_W-1:0] out_kv,
   output logic            pq_enq,
   output logic            pq_deq,
   output logic [KV_W-1:0] pq_kvi,
   input  logic [KV_W-1:0] pq_kvo,
   input  logic            pq_full,
   input  logic            pq_empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {ST_ISSUE, ST_WAIT} state_t;

   state_t                state_q, state_d;
   logic [KV_W-1:0]       mem_q [DEPTH];
   logic [KV_W-1:0]       mem_d [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  pop_pend_q, pop_pend_d;
   logic                  pq_enq_q, pq_enq_d, pq_deq_q, pq_deq_d;
   logic [KV_W-1:0]       pq_kvi_q, pq_kvi_d;
   logic                  out_valid_q, out_valid_d;
   logic [KV_W-1:0]       out_kv_q, out_kv_d;

   logic                  fifo_ne, push, new_higher, do_enq, do_deq;
   logic [KV_W-1:0]       fifo_head;
   logic [KEY_WIDTH-1:0]  new_key, head_key;

   always_comb begin
      fifo_ne    = (count_q != '0);
      in_ready   = (count_q < CW'(DEPTH));
      pop_ready  = !pop_pend_q && !out_valid_q;
      push       = in_valid && in_ready;
      fifo_head  = mem_q[rd_ptr_q];
      new_key    = fifo_head[KV_W-1 -: KEY_WIDTH];
      head_key   = pq_kvo[KV_W-1 -: KEY_WIDTH];
      // Equal keys are never "higher", so a tie still allows the combined replace.
      new_higher = MIN_FIRST ? (new_key < head_key) : (new_key > head_key);
   end

   always_comb begin
      state_d = state_q;
      do_enq  = 1'b0;
      do_deq  = 1'b0;
      case (state_q)
         ST_ISSUE: begin
            if (fifo_ne && pop_pend_q && !pq_empty && !new_higher) begin
               do_enq = 1'b1;
               do_deq = 1'b1;
            end else if (fifo_ne && !pq_full) begin
               do_enq = 1'b1;
            end else if (pop_pend_q && !pq_empty) begin
               do_deq = 1'b1;
            end
            if (do_enq || do_deq) state_d = ST_WAIT;
         end
         ST_WAIT: state_d = ST_ISSUE;
         default: state_d = ST_ISSUE;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_kv;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_enq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, do_enq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      pq_enq_d = do_enq;
      pq_deq_d = do_deq;
      pq_kvi_d = do_enq ? fifo_head : pq_kvi_q;

      pop_pend_d = pop_pend_q;
      if (do_deq)                    pop_pend_d = 1'b0;
      else if (pop_req && pop_ready) pop_pend_d = 1'b1;

      out_valid_d = out_valid_q;
      out_kv_d    = out_kv_q;
      if (do_deq) begin
         out_valid_d = 1'b1;
         out_kv_d    = pq_kvo;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ISSUE;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pop_pend_q  <= 1'b0;
         pq_enq_q    <= 1'b0;
         pq_deq_q    <= 1'b0;
         pq_kvi_q    <= '0;
         out_valid_q <= 1'b0;
         out_kv_q    <= '0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pop_pend_q  <= pop_pend_d;
         pq_enq_q    <= pq_enq_d;
         pq_deq_q    <= pq_deq_d;
         pq_kvi_q    <= pq_kvi_d;
         out_valid_q <= out_valid_d;
         out_kv_q    <= out_kv_d;
      end
   end

   assign pq_enq    = pq_enq_q;
   assign pq_deq    = pq_deq_q;
   assign pq_kvi    = pq_kvi_q;
   assign out_valid = out_valid_q;
   assign out_kv    = out_kv_q;

endmodule

// File: tb/tb_pq_ingress.sv
// Scoreboard bench for pq_ingress: a behavioural 4-entry min-first PQ answers the
// commands, expected PQ inserts and dequeued entries are queued and checked by a monitor.
module tb_pq_ingress;
   import pq_pkg::*;

   localparam int unsigned KV_W = KEY_WIDTH + VAL_WIDTH;
   localparam int          CAP  = 4;

   logic            clk = 1'b0;
   logic            rst_n, in_valid, pop_req, out_ready;
   logic [KV_W-1:0] in_kv;
   logic            in_ready, pop_ready, out_valid, pq_enq, pq_deq, pq_full, pq_empty;
   logic [KV_W-1:0] out_kv, pq_kvi, pq_kvo;

   int              checks = 0;
   int              errors = 0;
   int              n_enq = 0, n_deq = 0, n_both = 0;
   int              b_enq, b_deq, b_both;
   logic [KV_W-1:0] exp_enq[$];
   logic [KV_W-1:0] exp_out[$];

   logic [KV_W-1:0] pq_m[$];
   int              pq_sz = 0;
   logic [KV_W-1:0] pq_head = '0;
   logic            model_clr;

   always #5 clk = ~clk;

   pq_ingress #(.DEPTH(4), .MIN_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_kv(in_kv),
      .pop_req(pop_req), .pop_ready(pop_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_kv(out_kv),
      .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
      .pq_kvo(pq_kvo), .pq_full(pq_full), .pq_empty(pq_empty)
   );

   // Sorted ascending by key, ties keep arrival order; deq before enq on a replace.
   always @(negedge clk) begin
      if (model_clr) pq_m.delete();
      if (pq_deq && pq_m.size() > 0) void'(pq_m.pop_front());
      if (pq_enq) begin
         int pos;
         pos = pq_m.size();
         for (int i = 0; i < pq_m.size(); i++) begin
            if (pq_kvi[KV_W-1 -: KEY_WIDTH] < pq_m[i][KV_W-1 -: KEY_WIDTH]) begin
               pos = i;
               break;
            end
         end
         pq_m.insert(pos, pq_kvi);
      end
      pq_sz   = pq_m.size();
      pq_head = (pq_m.size() > 0) ? pq_m[0] : '0;
   end

   assign pq_kvo   = pq_head;
   assign pq_full  = (pq_sz == CAP);
   assign pq_empty = (pq_sz == 0);

   function automatic logic [KV_W-1:0] kv(input int k, input int v);
      return {k[KEY_WIDTH-1:0], v[VAL_WIDTH-1:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      logic            prev_cmd = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;
      logic [KV_W-1:0] prev_kv = '0;
      forever begin
         @(negedge clk);
         if (pq_enq || pq_deq) begin
            chk("cmd_spacing", 32'(prev_cmd), 0);
            if (pq_enq)           n_enq++;
            if (pq_deq)           n_deq++;
            if (pq_enq && pq_deq) n_both++;
         end
         if (pq_enq) begin
            if (exp_enq.size() == 0) chk("unexpected_enq", 32'(pq_kvi), 32'hffff_ffff);
            else chk("pq_kvi", 32'(pq_kvi), 32'(exp_enq.pop_front()));
         end
         if (prev_ov && !prev_or && out_valid) chk("out_kv_hold", 32'(out_kv), 32'(prev_kv));
         if (out_valid && out_ready) begin
            if (exp_out.size() == 0) chk("unexpected_out", 32'(out_kv), 32'hffff_ffff);
            else chk("out_kv", 32'(out_kv), 32'(exp_out.pop_front()));
         end
         prev_cmd = pq_enq | pq_deq;
         prev_ov  = out_valid;
         prev_or  = out_ready;
         prev_kv  = out_kv;
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [KV_W-1:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_kv    = d;
      while (!in_ready && n < 200) begin
         step(1);
         n++;
      end
      chk("push_timeout", 32'(n < 200), 1);
      step(1);
      in_valid = 1'b0;
   endtask

   task automatic pop();
      int n = 0;
      pop_req = 1'b1;
      while (!pop_ready && n < 200) begin
         step(1);
         n++;
      end
      chk("pop_timeout", 32'(n < 200), 1);
      step(1);
      pop_req = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_enq.size() != 0 || exp_out.size() != 0) && n < 200) begin
         step(1);
         n++;
      end
      chk({"drain_", name}, 32'(n < 200), 1);
      step(2);
   endtask

   task automatic base();
      b_enq  = n_enq;
      b_deq  = n_deq;
      b_both = n_both;
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_pq_enq"},    32'(pq_enq), 0);
      chk({name, "_pq_deq"},    32'(pq_deq), 0);
      chk({name, "_pq_kvi"},    32'(pq_kvi), 0);
      chk({name, "_out_valid"}, 32'(out_valid), 0);
      chk({name, "_out_kv"},    32'(out_kv), 0);
      chk({name, "_in_ready"},  32'(in_ready), 1);
      chk({name, "_pop_ready"}, 32'(pop_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [KV_W-1:0] xs [6];
      rst_n = 1'b0; in_valid = 1'b0; in_kv = '0; pop_req = 1'b0; out_ready = 1'b0;
      model_clr = 1'b0;
      fork
         monitor();
      join_none
      step(2);
      chk_reset("rst");
      rst_n = 1'b1;
      step(1);

      // 1) single insert
      base();
      exp_enq.push_back(kv(8, 14));
      push(kv(8, 14));
      chk("t1_in_ready", 32'(in_ready), 1);
      wait_idle("t1");
      chk("t1_enq_cnt", n_enq - b_enq, 1);
      chk("t1_pq_size", pq_sz, 1);

      // 2) replace: new key 9 not higher than head 8
      base();
      exp_enq.push_back(kv(9, 10));
      exp_out.push_back(kv(8, 14));
      in_valid = 1'b1; in_kv = kv(9, 10); pop_req = 1'b1;
      step(1);
      in_valid = 1'b0; pop_req = 1'b0;
      step(6);
      chk("t2_out_valid_held", 32'(out_valid), 1);
      chk("t2_pop_ready_low", 32'(pop_ready), 0);
      out_ready = 1'b1;
      wait_idle("t2");
      chk("t2_both_cnt", n_both - b_both, 1);
      chk("t2_deq_cnt", n_deq - b_deq, 1);

      // 3) higher-priority key is inserted first, then dequeued
      exp_enq.push_back(kv(8, 14));
      push(kv(8, 14));
      wait_idle("t3a");
      base();
      exp_enq.push_back(kv(2, 12));
      exp_out.push_back(kv(2, 12));
      in_valid = 1'b1; in_kv = kv(2, 12); pop_req = 1'b1;
      step(1);
      in_valid = 1'b0; pop_req = 1'b0;
      wait_idle("t3");
      chk("t3_both_cnt", n_both - b_both, 0);
      chk("t3_enq_cnt", n_enq - b_enq, 1);
      chk("t3_deq_cnt", n_deq - b_deq, 1);
      chk("t3_pq_size", pq_sz, 2);

      // 4) PQ full: FIFO fills and stalls, pops drain it via replaces
      exp_enq.push_back(kv(20, 1));
      exp_enq.push_back(kv(30, 2));
      push(kv(20, 1));
      push(kv(30, 2));
      wait_idle("t4a");
      chk("t4_pq_full", 32'(pq_full), 1);
      base();
      for (int i = 0; i < 4; i++) push(kv(40 + i, 3 + i));
      in_valid = 1'b1; in_kv = kv(44, 7);
      step(4);
      chk("t4_in_ready_full", 32'(in_ready), 0);
      in_valid = 1'b0;
      chk("t4_no_enq", n_enq - b_enq, 0);
      for (int i = 0; i < 5; i++) exp_enq.push_back(kv(40 + i, 3 + i));
      exp_out.push_back(kv(8, 14));
      exp_out.push_back(kv(9, 10));
      exp_out.push_back(kv(20, 1));
      exp_out.push_back(kv(30, 2));
      exp_out.push_back(kv(40, 3));
      pop();
      push(kv(44, 7));
      for (int i = 0; i < 4; i++) pop();
      wait_idle("t4");
      chk("t4_both_cnt", n_both - b_both, 5);
      chk("t4_pq_size", pq_sz, 4);
      chk("t4_in_ready", 32'(in_ready), 1);

      // 5) empty PQ with a pending pop waits for an insert
      for (int i = 0; i < 4; i++) exp_out.push_back(kv(41 + i, 4 + i));
      for (int i = 0; i < 4; i++) pop();
      wait_idle("t5a");
      chk("t5_pq_empty", 32'(pq_empty), 1);
      base();
      pop_req = 1'b1;
      step(1);
      pop_req = 1'b0;
      chk("t5_pop_ready_low", 32'(pop_ready), 0);
      step(8);
      chk("t5_no_enq", n_enq - b_enq, 0);
      chk("t5_no_deq", n_deq - b_deq, 0);
      chk("t5_no_out", 32'(out_valid), 0);
      exp_enq.push_back(kv(7, 7));
      exp_out.push_back(kv(7, 7));
      push(kv(7, 7));
      wait_idle("t5");
      chk("t5_enq_cnt", n_enq - b_enq, 1);
      chk("t5_deq_cnt", n_deq - b_deq, 1);
      chk("t5_both_cnt", n_both - b_both, 0);

      // 6) async reset while an enq is on the bus and the FIFO holds 3 entries
      for (int i = 0; i < 6; i++) xs[i] = kv(50 + i, i);
      exp_enq.push_back(xs[0]);
      exp_enq.push_back(xs[1]);
      exp_enq.push_back(xs[2]);
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_kv = xs[i];
         step(1);
      end
      chk("t6_enq_before_rst", 32'(pq_enq), 1);
      chk("t6_kvi_before_rst", 32'(pq_kvi), 32'(xs[2]));
      rst_n = 1'b0;
      in_valid = 1'b0;
      model_clr = 1'b1;
      #1;
      chk_reset("t6");
      chk("t6_enq_left", exp_enq.size(), 1);
      exp_enq.delete();
      @(negedge clk);
      #1 model_clr = 1'b0;
      chk("t6_pq_cleared", pq_sz, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      base();
      step(6);
      chk("t6_fifo_discarded", n_enq - b_enq, 0);
      chk("t6_in_ready", 32'(in_ready), 1);
      exp_enq.push_back(kv(60, 1));
      push(kv(60, 1));
      wait_idle("t6");
      chk("t6_enq_after", n_enq - b_enq, 1);

      chk("end_exp_enq_empty", exp_enq.size(), 0);
      chk("end_exp_out_empty", exp_out.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
